// File: rtl/mac_requant.sv
// Requantisation stage after the MAC accumulator: bias, optional ReLU,
// arithmetic right shift and saturation, in a two-stage valid/ready pipeline.
module mac_requant #(
    parameter int ACC_WIDTH   = 10,
    parameter int BIAS_WIDTH  = 10,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_WIDTH-1:0]   in_acc,
    input  logic [BIAS_WIDTH-1:0]  in_bias,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   sat_flag,
    output logic [15:0]            out_count
);

    localparam int SW = ((ACC_WIDTH + 1) > BIAS_WIDTH ?
                         (ACC_WIDTH + 1) : BIAS_WIDTH) + 1;

    localparam logic signed [SW-1:0] UMAX = SW'(2 ** OUT_WIDTH - 1);
    localparam logic signed [SW-1:0] SMAX = SW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (OUT_WIDTH - 1)));

    logic                   s1_valid_q, s1_valid_d;
    logic signed [SW-1:0]   s1_sum_q, s1_sum_d;
    logic [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
    logic                   s1_relu_q, s1_relu_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   sat_q, sat_d;
    logic [15:0]            out_count_q, out_count_d;

    logic                   adv1, adv2, load1, load2;
    logic signed [SW-1:0]   sum, r, t;
    logic                   hi_u, hi_s, lo_s;
    logic [OUT_WIDTH-1:0]   res;
    logic                   res_sat;

    always_comb begin
        adv2  = !out_valid_q || out_ready;
        adv1  = !s1_valid_q || adv2;
        load1 = in_valid && adv1;
        load2 = adv2 && s1_valid_q;

        sum = $signed({{(SW - ACC_WIDTH){1'b0}}, in_acc})
            + $signed({{(SW - BIAS_WIDTH){in_bias[BIAS_WIDTH-1]}}, in_bias});

        // ReLU zeroing happens before the shift so it never counts as clipping
        r = s1_sum_q;
        if (s1_relu_q && s1_sum_q[SW-1]) begin
            r = '0;
        end
        t = r >>> s1_shift_q;

        hi_u = s1_relu_q && (t > UMAX);
        hi_s = !s1_relu_q && (t > SMAX);
        lo_s = !s1_relu_q && (t < SMIN);

        res     = t[OUT_WIDTH-1:0];
        res_sat = 1'b0;
        unique case (1'b1)
            hi_u: begin
                res     = '1;
                res_sat = 1'b1;
            end
            hi_s: begin
                res     = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
                res_sat = 1'b1;
            end
            lo_s: begin
                res     = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
                res_sat = 1'b1;
            end
            default: begin
                res     = t[OUT_WIDTH-1:0];
                res_sat = 1'b0;
            end
        endcase

        s1_valid_d = adv1 ? in_valid : s1_valid_q;
        s1_sum_d   = load1 ? sum : s1_sum_q;
        s1_shift_d = load1 ? shift : s1_shift_q;
        s1_relu_d  = load1 ? relu_en : s1_relu_q;

        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        out_data_d  = load2 ? res : out_data_q;
        sat_d       = load2 ? res_sat : sat_q;
        out_count_d = out_count_q + {15'd0, out_valid_q && out_ready};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
            s1_relu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            out_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_shift_q  <= s1_shift_d;
            s1_relu_q   <= s1_relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: arithmetic corner cases, stall,
// mid-stream reset and out_count wrap.
module tb_mac_requant;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_acc = '0;
    logic [9:0] in_bias = '0;
    logic [3:0] shift = '0;
    logic       relu_en = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       sat_flag;
    logic [15:0] out_count;

    int n_tests = 0;
    int n_fail = 0;

    mac_requant dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_acc   (in_acc),
        .in_bias  (in_bias),
        .shift    (shift),
        .relu_en  (relu_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sat_flag (sat_flag),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_one(input string tag, input logic [9:0] acc,
                            input logic [9:0] bias, input logic [3:0] sh,
                            input logic relu, input logic [7:0] exp_d,
                            input logic exp_s);
        @(negedge clk);
        in_acc = acc;
        in_bias = bias;
        shift = sh;
        relu_en = relu;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp_d});
        check({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, exp_s});
    endtask

    logic [7:0] stream_exp [8] = '{8'd0, 8'd13, 8'd38, 8'd63,
                                   8'd88, 8'd113, 8'd138, 8'd163};

    initial begin
        int sent;
        int rcv;
        int stall_seen;
        int stale;

        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_sat", {31'd0, sat_flag}, 32'd0);
        check("rst_count", {16'd0, out_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        send_one("basic", 10'd100, 10'(-20), 4'd2, 1'b1, 8'd20, 1'b0);
        send_one("relu_neg", 10'd10, 10'(-50), 4'd0, 1'b1, 8'd0, 1'b0);
        send_one("sgn_neg", 10'd10, 10'(-50), 4'd0, 1'b0, 8'hD8, 1'b0);
        send_one("sat_u", 10'd1023, 10'd511, 4'd0, 1'b1, 8'd255, 1'b1);
        send_one("sat_s", 10'd1023, 10'd511, 4'd0, 1'b0, 8'd127, 1'b1);
        send_one("sh3", 10'd1023, 10'd511, 4'd3, 1'b1, 8'd191, 1'b0);
        send_one("sh15_pos", 10'd1023, 10'd511, 4'd15, 1'b0, 8'd0, 1'b0);
        send_one("sh15_neg", 10'd0, 10'(-512), 4'd15, 1'b0, 8'hFF, 1'b0);
        send_one("sat_lo", 10'd0, 10'(-512), 4'd0, 1'b0, 8'h80, 1'b1);
        @(negedge clk);
        #1 check("count_9", {16'd0, out_count}, 32'd9);

        // Eight-beat stream with a four-cycle consumer stall
        do_reset();
        sent = 0;
        rcv = 0;
        stall_seen = 0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid = (sent < 8);
            in_acc = 10'(50 * sent + 7);
            in_bias = 10'(-30);
            shift = 4'd1;
            relu_en = 1'b1;
            #1;
            if (!in_ready && stall_seen == 0) begin
                stall_seen = 1;
                check("buffered", 32'(sent - rcv), 32'd2);
            end
            if (out_valid) begin
                check("stream_data", {24'd0, out_data},
                      {24'd0, stream_exp[rcv]});
                check("stream_sat", {31'd0, sat_flag}, 32'd0);
                if (out_ready) rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("stream_rcv", 32'(rcv), 32'd8);
        check("stall_seen", 32'(stall_seen), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("stream_count", {16'd0, out_count}, 32'd8);

        // Reset with two beats in flight
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_acc = 10'd40;
            in_bias = 10'd0;
            shift = 4'd0;
            relu_en = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {16'd0, out_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 if (out_valid) stale++;
        end
        check("no_stale", 32'(stale), 32'd0);

        // out_count wrap: 0xFFFE handshakes then 3 more
        do_reset();
        sent = 0;
        in_acc = 10'd1;
        in_bias = 10'd0;
        for (int cyc = 0; cyc < 70000 && sent < 32'hFFFE; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1 if (in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("count_fffe", {16'd0, out_count}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("count_wrap", {16'd0, out_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
